main_fsm: RTL and testbench
===========================

# main_fsm

Multicycle control state machine for the RISC-V core. It sits directly upstream of the ALU decoder. It takes the opcode of the instruction held in the instruction register, steps through fetch, decode and execute phases, and drives the datapath strobes and mux selects, including the 2-bit `ALUOp` that the ALU decoder turns into `ALUControl`. Outputs are Moore (a function of state only), except `PCWrite`, which also depends on the ALU `Zero` flag.

## Interface
- No parameters. State encoding is fixed (see Operation).
- `clk` in 1: single clock; all state updates occur on its rising edge.
- `reset` in 1: synchronous, active-high; sampled on the `clk` rising edge.
- `op` in 7: opcode field `Instr[6:0]` from the instruction register.
- `Zero` in 1: ALU zero flag.
- `PCWrite` out 1: PC register enable; equals `PCUpdate | (Branch & Zero)`.
- `AdrSrc` out 1: memory address select; 0 selects PC, 1 selects the ALU result register.
- `MemWrite` out 1: data memory write enable.
- `IRWrite` out 1: instruction register enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: result mux select; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A-input select; 00 = PC, 01 = OldPC, 10 = rs1 register.
- `ALUSrcB` out 2: ALU B-input select; 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- `ALUOp` out 2: goes to the ALU decoder; 00 = add, 01 = subtract, 10 = decode by funct3/funct7.
- `IllegalOp` out 1: high while the FSM is in the ERR state.
- `State` out 4: current state code, for debug and verification.

## Operation
State codes:
- FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, ERR=15.
- Codes 11–14 are unreachable. If ever entered, the next state is FETCH.

Transitions:
- FETCH → DECODE, unconditionally.
- DECODE dispatches on `op`:
  - 0000011 (lw) or 0100011 (sw) → MEMADR
  - 0110011 (R-type) → EXECUTER
  - 0010011 (I-ALU) → EXECUTEI
  - 1100011 (beq) → BEQ
  - 1101111 (jal) → JAL
  - any other opcode → ERR
- MEMADR → MEMREAD if `op`=0000011; otherwise → MEMWRITE.
- MEMREAD → MEMWB.
- MEMWB, MEMWRITE, BEQ → FETCH.
- EXECUTER, EXECUTEI, JAL → ALUWB.
- ALUWB → FETCH.
- ERR → ERR; only `reset` exits it.

Outputs per state. Any signal not listed is 0.
- FETCH: IRWrite=1, PCUpdate=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- ERR: IllegalOp=1.
- `PCUpdate` and `Branch` are internal signals, not ports.
- All outputs are fully decoded. No X values are driven in any state, including unreachable codes, which produce all-zero outputs.

## Timing
- State register: `State` ← FETCH on any rising edge where `reset`=1. Otherwise `State` ← next state.
- Reset takes priority over every transition, including ERR and mid-instruction states. For example, reset asserted in MEMWRITE means FETCH on the next cycle, and MemWrite is low from that cycle onward.
- Output values after reset are those of FETCH: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, all others 0, `State`=0, `IllegalOp`=0.
- Moore outputs change only after a rising edge. `PCWrite` follows `Zero` combinationally in BEQ within the same cycle.
- `op` is sampled only in DECODE and MEMADR. The instruction register must hold `op` stable until FETCH, which is guaranteed because IRWrite=1 only in FETCH.
- Cycles per instruction:
  - lw: 5 (FETCH, DECODE, MEMADR, MEMREAD, MEMWB)
  - sw: 4
  - R-type / I-ALU: 4
  - jal: 4
  - beq: 3
- Single-cycle strobes: IRWrite, MemWrite and RegWrite are each high for exactly one cycle per instruction that uses them.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with `op`=X → `State`=0, IRWrite=1, PCWrite=1, MemWrite=0, RegWrite=0, IllegalOp=0.
- lw: `op`=0000011 → `State` sequence 0,1,2,3,4,0. RegWrite=1 only in state 4 with ResultSrc=01. AdrSrc=1 only in state 3.
- R-type then I-type: `op`=0110011 → 0,1,6,8,0 with ALUOp=10 in state 6 and ALUSrcB=00. `op`=0010011 → state 7 with ALUSrcB=01.
- beq:
  - `op`=1100011 with `Zero`=1 in state 9 → PCWrite=1, ALUOp=01.
  - Repeat with `Zero`=0 → PCWrite=0.
  - Toggle `Zero` mid-cycle in state 9 → PCWrite tracks it combinationally.
- sw and jal:
  - `op`=0100011 → 0,1,2,5,0 with MemWrite=1 only in state 5.
  - `op`=1101111 → 0,1,10,8,0 with PCWrite=1 in state 10 and ALUSrcA=01.
- Illegal opcode and reset mid-operation:
  - `op`=1111111 in DECODE → `State`=15, IllegalOp=1 held for 10 cycles.
  - Assert `reset` → FETCH on the next edge.
  - Assert `reset` during state 5 → MemWrite=0 on the next cycle and `State`=0.

Source files
------------

// File: rtl/main_fsm_if.sv
// Control bundle between the multicycle main FSM and the datapath.
// The FSM side takes the master modport; the datapath side takes slave.
interface main_fsm_if;
   logic [6:0] op;
   logic       Zero;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic       IllegalOp;
   logic [3:0] State;

   modport master (
      input  op,
      input  Zero,
      output PCWrite,
      output AdrSrc,
      output MemWrite,
      output IRWrite,
      output RegWrite,
      output ResultSrc,
      output ALUSrcA,
      output ALUSrcB,
      output ALUOp,
      output IllegalOp,
      output State
   );

   modport slave (
      output op,
      output Zero,
      input  PCWrite,
      input  AdrSrc,
      input  MemWrite,
      input  IRWrite,
      input  RegWrite,
      input  ResultSrc,
      input  ALUSrcA,
      input  ALUSrcB,
      input  ALUOp,
      input  IllegalOp,
      input  State
   );
endinterface

// File: rtl/main_fsm.sv
// Multicycle RISC-V main control FSM: fetch/decode/execute sequencing.
// Moore strobes per state; PCWrite also folds in the branch Zero flag.
module main_fsm (
   input logic        clk,
   input logic        reset,
   main_fsm_if.master bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10,
      ERR      = 4'd15
   } state_e;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   state_e state_q, state_d;

   logic is_mem, is_r, is_i, is_beq, is_jal;

   logic       pc_update;
   logic       branch;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       illegal;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   assign is_mem = (bus.op == OP_LW) || (bus.op == OP_SW);
   assign is_r   = (bus.op == OP_R);
   assign is_i   = (bus.op == OP_I);
   assign is_beq = (bus.op == OP_BEQ);
   assign is_jal = (bus.op == OP_JAL);

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH: state_d = DECODE;
         DECODE: begin
            state_d = ERR;
            unique case (1'b1)
               is_mem:  state_d = MEMADR;
               is_r:    state_d = EXECUTER;
               is_i:    state_d = EXECUTEI;
               is_beq:  state_d = BEQ;
               is_jal:  state_d = JAL;
               default: state_d = ERR;
            endcase
         end
         MEMADR: begin
            if (bus.op == OP_LW) state_d = MEMREAD;
            else                 state_d = MEMWRITE;
         end
         MEMREAD:  state_d = MEMWB;
         MEMWB:    state_d = FETCH;
         MEMWRITE: state_d = FETCH;
         EXECUTER: state_d = ALUWB;
         EXECUTEI: state_d = ALUWB;
         JAL:      state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         BEQ:      state_d = FETCH;
         // Only reset leaves the error trap.
         ERR:      state_d = ERR;
         default:  state_d = FETCH;
      endcase
   end

   always_comb begin
      pc_update  = 1'b0;
      branch     = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      illegal    = 1'b0;
      case (state_q)
         FETCH: begin
            ir_write   = 1'b1;
            pc_update  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         MEMREAD: begin
            adr_src = 1'b1;
         end
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         EXECUTER: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         EXECUTEI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         ALUWB: begin
            reg_write = 1'b1;
         end
         BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
         end
         JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
         end
         ERR: begin
            illegal = 1'b1;
         end
         default: begin
            illegal = 1'b0;
         end
      endcase
   end

   assign bus.PCWrite   = pc_update | (branch & bus.Zero);
   assign bus.AdrSrc    = adr_src;
   assign bus.MemWrite  = mem_write;
   assign bus.IRWrite   = ir_write;
   assign bus.RegWrite  = reg_write;
   assign bus.ResultSrc = result_src;
   assign bus.ALUSrcA   = alu_src_a;
   assign bus.ALUSrcB   = alu_src_b;
   assign bus.ALUOp     = alu_op;
   assign bus.IllegalOp = illegal;
   assign bus.State     = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: walks every instruction class,
// the branch Zero path, the error trap and mid-instruction reset.
module tb_main_fsm;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   main_fsm_if bus ();

   main_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
   //  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, IllegalOp}
   localparam logic [17:0] E_FETCH =
      {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
       2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
   localparam logic [17:0] E_DECODE =
      {4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
       2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
   localparam logic [17:0] E_MEMADR =
      {4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
       2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
   localparam logic [17:0] E_MEMREAD =
      {4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
       2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [17:0] E_MEMWB =
      {4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
       2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [17:0] E_MEMWRITE =
      {4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
       2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [17:0] E_EXECR =
      {4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
       2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
   localparam logic [17:0] E_EXECI =
      {4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
       2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
   localparam logic [17:0] E_ALUWB =
      {4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
       2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [17:0] E_BEQ_T =
      {4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
       2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
   localparam logic [17:0] E_BEQ_N =
      {4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
       2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
   localparam logic [17:0] E_JAL =
      {4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
       2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
   localparam logic [17:0] E_ERR =
      {4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
       2'b00, 2'b00, 2'b00, 2'b00, 1'b1};

   function automatic logic [17:0] observed();
      return {bus.State, bus.PCWrite, bus.AdrSrc,
              bus.MemWrite, bus.IRWrite, bus.RegWrite,
              bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
              bus.ALUOp, bus.IllegalOp};
   endfunction

   task automatic chk(input string tag, input logic [17:0] exp);
      logic [17:0] obs;
      obs = observed();
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      reset    = 1'b1;
      bus.op   = 'x;
      bus.Zero = 1'b0;
      @(negedge clk);
      step();
      step();
      chk("reset", E_FETCH);

      // lw: 0,1,2,3,4,0
      reset  = 1'b0;
      bus.op = 7'b0000011;
      step(); chk("lw_dec", E_DECODE);
      step(); chk("lw_adr", E_MEMADR);
      step(); chk("lw_rd", E_MEMREAD);
      step(); chk("lw_wb", E_MEMWB);
      step(); chk("lw_fetch", E_FETCH);

      // R-type: 0,1,6,8,0
      bus.op = 7'b0110011;
      step(); chk("r_dec", E_DECODE);
      step(); chk("r_exec", E_EXECR);
      step(); chk("r_wb", E_ALUWB);
      step(); chk("r_fetch", E_FETCH);

      // I-ALU: 0,1,7,8,0
      bus.op = 7'b0010011;
      step(); chk("i_dec", E_DECODE);
      step(); chk("i_exec", E_EXECI);
      step(); chk("i_wb", E_ALUWB);
      step(); chk("i_fetch", E_FETCH);

      // beq taken, with Zero toggled inside the BEQ cycle
      bus.op   = 7'b1100011;
      bus.Zero = 1'b1;
      step(); chk("beq_dec", E_DECODE);
      step(); chk("beq_taken", E_BEQ_T);
      bus.Zero = 1'b0;
      #1 chk("beq_zero_fall", E_BEQ_N);
      bus.Zero = 1'b1;
      #1 chk("beq_zero_rise", E_BEQ_T);
      step(); chk("beq_fetch", E_FETCH);

      // beq not taken
      bus.Zero = 1'b0;
      step(); chk("beqn_dec", E_DECODE);
      step(); chk("beq_not_taken", E_BEQ_N);
      step(); chk("beqn_fetch", E_FETCH);

      // sw: 0,1,2,5,0
      bus.op = 7'b0100011;
      step(); chk("sw_dec", E_DECODE);
      step(); chk("sw_adr", E_MEMADR);
      step(); chk("sw_wr", E_MEMWRITE);
      step(); chk("sw_fetch", E_FETCH);

      // jal: 0,1,10,8,0
      bus.op = 7'b1101111;
      step(); chk("jal_dec", E_DECODE);
      step(); chk("jal_exec", E_JAL);
      step(); chk("jal_wb", E_ALUWB);
      step(); chk("jal_fetch", E_FETCH);

      // illegal opcode traps in ERR until reset
      bus.op = 7'b1111111;
      step(); chk("ill_dec", E_DECODE);
      for (int i = 0; i < 10; i++) begin
         step(); chk("ill_hold", E_ERR);
      end
      reset = 1'b1;
      step(); chk("ill_reset", E_FETCH);
      reset = 1'b0;

      // reset during MEMWRITE
      bus.op = 7'b0100011;
      step(); chk("rs_dec", E_DECODE);
      step(); chk("rs_adr", E_MEMADR);
      step(); chk("rs_wr", E_MEMWRITE);
      reset = 1'b1;
      step(); chk("rs_fetch", E_FETCH);
      reset = 1'b0;
      step(); chk("rs_resume", E_DECODE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
